// File: rtl/adder_nbit_top.sv
// ---------------------------------------------------------------------------
// adder_nbit_top
//   Registered N-bit unsigned adder with a seven-segment hex readout of the
//   low nibble of the sum. One cycle of latency; outputs come straight from
//   flops, so there is no combinational path from any input to any output.
//
// Parameters
//   N        operand width in bits (1..16)
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_a      unsigned operand A, N bits
//   i_b      unsigned operand B, N bits
//   o_sum    registered sum, N+1 bits (MSB is carry out)
//   o_HEX    registered segment pattern of o_sum[3:0], bit0=a .. bit6=g
//
// Configuration
//   ADDER_HEX_ACTIVE_LOW_EN  when defined, o_HEX (including its reset value)
//                            is driven active-low (0 = segment lit).
//                            o_sum is unaffected.
// ---------------------------------------------------------------------------
module adder_nbit_top #(
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N:0]   o_sum,
  output logic [6:0]   o_HEX
);

`ifdef ADDER_HEX_ACTIVE_LOW_EN
  localparam logic [6:0] HEX_POL_MASK = 7'h7F;
`else
  localparam logic [6:0] HEX_POL_MASK = 7'h00;
`endif

  // Active-high segment patterns, g..a
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Polarity is applied in one place so every pattern, reset included,
  // follows the same convention.
  function automatic logic [6:0] seg7_drive(input logic [3:0] digit);
    return seg7_decode(digit) ^ HEX_POL_MASK;
  endfunction

  localparam logic [6:0] HEX_RESET = 7'h3F ^ HEX_POL_MASK;

  // ---- stage p0: combinational add and nibble select ----
  logic [N:0] sum_p0;
  logic [3:0] nib_p0;

  // Both operands are widened before adding so the carry is kept.
  assign sum_p0 = {1'b0, i_a} + {1'b0, i_b};

  // Narrow sums are zero-extended to a full nibble; wide sums only show
  // their low four bits on the display.
  if (N >= 3) begin : g_nib_wide
    assign nib_p0 = sum_p0[3:0];
  end else begin : g_nib_narrow
    assign nib_p0 = {{(3-N){1'b0}}, sum_p0};
  end

  // ---- stage p1: output registers ----
  logic [N:0] sum_p1;
  logic [6:0] hex_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_p1 <= '0;
      hex_p1 <= HEX_RESET;
    end else begin
      sum_p1 <= sum_p0;
      hex_p1 <= seg7_drive(nib_p0);
    end
  end

  assign o_sum = sum_p1;
  assign o_HEX = hex_p1;

endmodule

// File: tb/tb_adder_nbit_top.sv
module tb_adder_nbit_top;
  localparam int N = 3;

`ifdef ADDER_HEX_ACTIVE_LOW_EN
  localparam logic [6:0] POL = 7'h7F;
`else
  localparam logic [6:0] POL = 7'h00;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   sum;
  logic [6:0]   hex;

  adder_nbit_top #(.N(N)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_a  (a),
    .i_b  (b),
    .o_sum(sum),
    .o_HEX(hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N:0] sum;
    logic [6:0] hex;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference table of active-high patterns, digits 0..F
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};

  // Monitor: every falling edge, if an output is expected, pop and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (sum !== e.sum) begin
        n_fail++;
        $display("FAIL %s sum: got %0d expected %0d", e.name, sum, e.sum);
      end
      n_tests++;
      if (hex !== e.hex) begin
        n_fail++;
        $display("FAIL %s hex: got 0x%02h expected 0x%02h", e.name, hex, e.hex);
      end
    end
  end

  // Drive one cycle of stimulus; exp_hex is given active-high and the
  // build polarity is applied here. hold >= 0 also checks that o_sum has
  // not moved before the sampling edge.
  task automatic drive(input int ia, input int ib, input logic r,
                       input int exp_sum, input logic [6:0] exp_hex,
                       input string nm, input int hold);
    exp_t e;
    @(negedge clk);
    a   = ia[N-1:0];
    b   = ib[N-1:0];
    rst = r;
    if (hold >= 0) begin
      #1;
      n_tests++;
      if (sum !== hold[N:0]) begin
        n_fail++;
        $display("FAIL %s hold: got %0d expected %0d", nm, sum, hold);
      end
    end
    @(posedge clk);
    e.sum  = exp_sum[N:0];
    e.hex  = exp_hex ^ POL;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;

    // Reset with live operands present; they must be discarded
    drive(5, 6, 1'b1, 0, 7'h3F, "rst0", -1);
    drive(5, 6, 1'b1, 0, 7'h3F, "rst1", -1);

    // First sum after release; output must still read 0 before the edge
    drive(3, 4, 1'b0, 7,  7'h07, "add3_4", 0);
    drive(7, 7, 1'b0, 14, 7'h79, "add7_7", -1);
    drive(0, 0, 1'b0, 0,  7'h3F, "add0_0", -1);
    drive(5, 0, 1'b0, 5,  7'h6D, "add5_0", -1);

    // Exhaustive sweep of all operand pairs
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        drive(i, j, 1'b0, i + j, seg_tab[(i + j) % 16],
              $sformatf("sweep%0d_%0d", i, j), -1);
      end
    end

    // Mid-stream reset, then recovery one edge after release
    drive(6, 5, 1'b0, 11, 7'h7C, "pre_rst", -1);
    drive(6, 5, 1'b1, 0,  7'h3F, "mid_rst", -1);
    drive(2, 3, 1'b0, 5,  7'h6D, "post_rst", -1);
    drive(1, 1, 1'b0, 2,  7'h5B, "post_rst2", 5);

    // Let the monitor drain the last expectations
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_nbit_top.md
ADDER_NBIT_TOP -- requirements
Module: adder_nbit_top

Interface
REQ-001 The block SHALL have parameter N, default 3: operand width in bits, legal range 1..16.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 i_rst  input  1  reset; synchronous and active-high.
REQ-004 i_a  input  N  unsigned operand A.
REQ-005 i_b  input  N  unsigned operand B.
REQ-006 o_sum  output  N+1  unsigned registered sum; the MSB is the carry out.
REQ-007 o_HEX  output  7  registered seven-segment pattern; bit0=a, bit1=b, ... bit6=g.

Function
REQ-008 On each rising i_clk edge with i_rst low, o_sum SHALL load i_a + i_b, computed at N+1 bits with no truncation.
REQ-009 Latency SHALL be exactly 1 cycle: inputs sampled at edge k appear on o_sum and o_HEX after edge k.
REQ-010 o_HEX SHALL update on the same edge as o_sum and always display the value currently on o_sum.
REQ-011 o_HEX SHALL encode the low 4 bits of the new sum as a hex digit. Active-high patterns (g..a), i.e. 1 = segment lit:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
REQ-012 When N < 3, the sum SHALL be zero-extended to 4 bits before decoding.
REQ-013 When N > 3, sum bits above bit 3 SHALL be ignored by the decoder; o_sum still carries the full width.
REQ-014 Maximum sum 2*(2^N-1) SHALL be represented exactly on o_sum, with no wrap-around.
REQ-015 The block SHALL contain no combinational path from any input to any output.
REQ-016 Unknown (X) inputs are not required to produce defined outputs; all other input values SHALL produce defined outputs.

Reset
REQ-017 While i_rst is high at a rising edge, o_sum SHALL become 0 and o_HEX SHALL become the pattern for digit 0 (0x3F, or the inverted form per REQ-020).
REQ-018 Reset SHALL take priority over the addition; operands present during reset are discarded.
REQ-019 Reset asserted mid-stream SHALL clear outputs on that edge, and the first sum SHALL appear on the edge after i_rst is sampled low.

Configuration
REQ-020 Macro ADDER_HEX_ACTIVE_LOW_EN:
  - Defined: every o_HEX pattern, including the reset value, SHALL be the bitwise inverse of REQ-011 (0 = segment lit; reset value 0x40).
  - Undefined: o_HEX SHALL be active-high exactly as in REQ-011.
  - o_sum SHALL be unaffected either way.

Verification (N=3 unless stated)
REQ-021 Assert i_rst for 2 cycles with i_a=5, i_b=6 -> o_sum=0, o_HEX=0x3F.
REQ-022 Release reset; i_a=3, i_b=4 -> one edge later o_sum=7, o_HEX=0x07; o_sum does not change before that edge.
REQ-023 i_a=7, i_b=7 -> o_sum=14 (4'b1110), o_HEX=0x79; i_a=0, i_b=0 -> o_sum=0, o_HEX=0x3F.
REQ-024 Exhaustive sweep of all 64 (i_a, i_b) pairs, one per cycle -> each o_sum equals i+j one cycle later, and each o_HEX matches the REQ-011 table.
REQ-025 Apply i_a=6, i_b=5; assert i_rst on the next edge -> o_sum=0 and o_HEX=0x3F on that edge; deassert -> the next sum appears one edge later.
REQ-026 With ADDER_HEX_ACTIVE_LOW_EN defined: reset -> o_HEX=0x40; i_a=5, i_b=0 -> o_sum=5, o_HEX=0x12.
